i2c_reg_ctrl: RTL and testbench
===============================

Name: i2c_reg_ctrl

Overview:
Write sequencer between the I2C slave front-end and the LED controller register bank. It converts the slave's level-style address_valid/data_valid flags and its start/stop strobes into single-cycle register-write strobes, with a register pointer and range checking. It issues one commit strobe per write transaction, so the LED driver latches a consistent register set only at I2C STOP.

Parameters:
NUM_REGS, 16, number of implemented LED registers; valid addresses are 0..NUM_REGS-1.
ADDR_W, 4, width of the register pointer; must satisfy 2**ADDR_W >= NUM_REGS.
DATA_W, 8, register data width; must equal the slave's 8-bit data bus.

Ports:
clk  in  1  system clock.
reset  in  1  synchronous, active-high reset.
start_i  in  1  I2C START / repeated-START strobe from the slave.
stop_i  in  1  I2C STOP strobe from the slave.
address_valid_i  in  1  level; goes high once the register-address byte is received and stays high until the next START.
address_i  in  8  register address byte from the slave.
data_valid_i  in  1  level; high after each data byte, then low again during the following ACK.
data_i  in  DATA_W  data byte from the slave.
reg_wr_en_o  out  1  one-cycle register write strobe.
reg_wr_addr_o  out  ADDR_W  write address.
reg_wr_data_o  out  DATA_W  write data.
commit_o  out  1  one-cycle strobe; the LED driver copies the shadow registers to the active set.
busy_o  out  1  high whenever state != IDLE.
err_o  out  1  sticky; the current transaction addressed a register >= NUM_REGS.

Behaviour:
- Reset: all outputs 0; state IDLE; ptr=0; dirty=0; edge-detect registers cleared. Reset mid-transaction discards pending writes and produces no commit.
- Rising edges of address_valid_i and data_valid_i are detected against a one-cycle-delayed copy. Only rising edges act.
- States: IDLE, ADDR_WAIT, DATA_WAIT, WRITE, COMMIT.
- IDLE: on start_i go to ADDR_WAIT.
- ADDR_WAIT: on an address_valid rising edge:
  - ptr <= address_i[ADDR_W-1:0].
  - If address_i >= NUM_REGS: err_o <= 1 and set the internal flag suppress=1.
  - Go to DATA_WAIT.
- DATA_WAIT: on a data_valid rising edge, capture data_i and go to WRITE.
- WRITE: lasts one cycle.
  - If suppress=0: reg_wr_en_o=1, reg_wr_addr_o=ptr, reg_wr_data_o=captured byte; dirty <= 1.
  - Advance ptr per the optional feature.
  - Return to DATA_WAIT.
- Latency: data_valid rising edge sampled in cycle N -> reg_wr_en_o high in cycle N+1, for exactly one cycle.
- stop_i in ADDR_WAIT or DATA_WAIT: if dirty, go to COMMIT; otherwise go to IDLE.
- stop_i during WRITE: the write completes; the stop is remembered; COMMIT follows in the next cycle.
- COMMIT: commit_o=1 for one cycle; dirty <= 0; go to IDLE.
- start_i in any non-IDLE state (repeated START): go to ADDR_WAIT; clear err_o and suppress; dirty is kept.
  - Exception: start_i during WRITE is deferred one cycle, so the write is never lost.
  - start_i during COMMIT: the commit completes, then go to ADDR_WAIT.
- start_i and stop_i in the same cycle: start wins.
- Read transactions (address_valid but no data) leave dirty=0 and produce no commit.
- err_o is cleared on the next start_i or on reset.

Optional Feature:
Macro I2C_REG_CTRL_AUTOINC_EN.
- Defined: after each WRITE, ptr increments by 1; ptr = NUM_REGS-1 wraps to 0. A wrap does not set err_o.
- Undefined: ptr is held, so all data bytes of a transaction write the same register.
- Suppress behaviour is identical in both builds.

Test Plan:
- Reset, then START, addr 0x03, data 0xAA, STOP -> one strobe (addr 3, data 0xAA) one cycle after the data_valid rise; commit_o pulses once; busy_o returns to 0.
- AUTOINC_EN defined: addr 0x0E, data 0x11/0x22/0x33, STOP -> writes at 14, 15, 0; one commit. Without the macro -> three writes at 14.
- addr 0x20 with NUM_REGS=16, data 0x55, STOP -> no reg_wr_en_o; err_o=1; no commit_o; err_o clears on the next START.
- Write at addr 2, repeated START, addr 5 with no data, STOP -> single commit_o after the final STOP only.
- stop_i in the same cycle as WRITE -> reg_wr_en_o still pulses; commit_o follows in the next cycle.
- reset asserted in DATA_WAIT after one write -> all outputs 0; a following STOP produces no commit_o.

Source files
------------

// File: rtl/i2c_reg_ctrl.sv
// Write sequencer between the I2C slave front-end and the LED register bank.
// Optional pointer auto-increment after each write: define I2C_REG_CTRL_AUTOINC_EN.
module i2c_reg_ctrl #(
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic              address_valid_i,
  input  logic [7:0]        address_i,
  input  logic              data_valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              reg_wr_en_o,
  output logic [ADDR_W-1:0] reg_wr_addr_o,
  output logic [DATA_W-1:0] reg_wr_data_o,
  output logic              commit_o,
  output logic              busy_o,
  output logic              err_o
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ADDR_WAIT = 3'd1,
    S_DATA_WAIT = 3'd2,
    S_WRITE     = 3'd3,
    S_COMMIT    = 3'd4
  } state_t;

  localparam logic [8:0]        NUM_REGS_L = 9'(NUM_REGS);
  localparam logic [ADDR_W-1:0] LAST_PTR   = ADDR_W'(NUM_REGS - 1);

  state_t              state_q;
  logic                av_q;
  logic                dv_q;
  logic                suppress_q;
  logic                dirty_q;
  logic                err_q;
  logic [ADDR_W-1:0]   ptr_q;
  logic [ADDR_W-1:0]   ptr_d;
  logic                reg_wr_en_q;
  logic [ADDR_W-1:0]   reg_wr_addr_q;
  logic [DATA_W-1:0]   reg_wr_data_q;
  logic                commit_q;

  logic av_rise;
  logic dv_rise;
  logic addr_oob;

  assign av_rise  = address_valid_i & ~av_q;
  assign dv_rise  = data_valid_i & ~dv_q;
  assign addr_oob = ({1'b0, address_i} >= NUM_REGS_L);

  // Pointer value to use after a write completes.
  always_comb begin
`ifdef I2C_REG_CTRL_AUTOINC_EN
    if (ptr_q == LAST_PTR) begin
      ptr_d = {ADDR_W{1'b0}};
    end else begin
      ptr_d = ptr_q + ADDR_W'(1);
    end
`else
    ptr_d = ptr_q;
`endif
  end

  // Transaction sequencer; strobes are issued on the edge entering WRITE/COMMIT
  // so they are visible for exactly the one cycle spent in that state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      av_q          <= 1'b0;
      dv_q          <= 1'b0;
      suppress_q    <= 1'b0;
      dirty_q       <= 1'b0;
      err_q         <= 1'b0;
      ptr_q         <= {ADDR_W{1'b0}};
      reg_wr_en_q   <= 1'b0;
      reg_wr_addr_q <= {ADDR_W{1'b0}};
      reg_wr_data_q <= {DATA_W{1'b0}};
      commit_q      <= 1'b0;
    end else begin
      av_q        <= address_valid_i;
      dv_q        <= data_valid_i;
      reg_wr_en_q <= 1'b0;
      commit_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_q    <= S_ADDR_WAIT;
            err_q      <= 1'b0;
            suppress_q <= 1'b0;
          end
        end
        S_ADDR_WAIT, S_DATA_WAIT: begin
          if (start_i) begin
            state_q    <= S_ADDR_WAIT;
            err_q      <= 1'b0;
            suppress_q <= 1'b0;
          end else if (stop_i) begin
            if (dirty_q) begin
              state_q  <= S_COMMIT;
              commit_q <= 1'b1;
              dirty_q  <= 1'b0;
            end else begin
              state_q <= S_IDLE;
            end
          end else if ((state_q == S_ADDR_WAIT) && av_rise) begin
            ptr_q   <= address_i[ADDR_W-1:0];
            state_q <= S_DATA_WAIT;
            if (addr_oob) begin
              err_q      <= 1'b1;
              suppress_q <= 1'b1;
            end
          end else if ((state_q == S_DATA_WAIT) && dv_rise) begin
            state_q <= S_WRITE;
            if (!suppress_q) begin
              reg_wr_en_q   <= 1'b1;
              reg_wr_addr_q <= ptr_q;
              reg_wr_data_q <= data_i;
              dirty_q       <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          // The strobe is already out; a START or STOP seen here acts only now.
          ptr_q <= ptr_d;
          if (start_i) begin
            state_q    <= S_ADDR_WAIT;
            err_q      <= 1'b0;
            suppress_q <= 1'b0;
          end else if (stop_i && dirty_q) begin
            state_q  <= S_COMMIT;
            commit_q <= 1'b1;
            dirty_q  <= 1'b0;
          end else if (stop_i) begin
            state_q <= S_IDLE;
          end else begin
            state_q <= S_DATA_WAIT;
          end
        end
        S_COMMIT: begin
          if (start_i) begin
            state_q    <= S_ADDR_WAIT;
            err_q      <= 1'b0;
            suppress_q <= 1'b0;
          end else begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign reg_wr_en_o   = reg_wr_en_q;
  assign reg_wr_addr_o = reg_wr_addr_q;
  assign reg_wr_data_o = reg_wr_data_q;
  assign commit_o      = commit_q;
  assign busy_o        = (state_q != S_IDLE);
  assign err_o         = err_q;

endmodule

// File: tb/tb_i2c_reg_ctrl.sv
// Self-checking bench for i2c_reg_ctrl: protocol-level transaction model,
// per-cycle output comparison, directed literal checks and randomized traffic.
module tb_i2c_reg_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_i = 1'b0;
  logic       stop_i = 1'b0;
  logic       address_valid_i = 1'b0;
  logic [7:0] address_i = 8'h00;
  logic       data_valid_i = 1'b0;
  logic [7:0] data_i = 8'h00;
  logic       reg_wr_en_o;
  logic [3:0] reg_wr_addr_o;
  logic [7:0] reg_wr_data_o;
  logic       commit_o;
  logic       busy_o;
  logic       err_o;

  i2c_reg_ctrl #(.NUM_REGS(16), .ADDR_W(4), .DATA_W(8)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .stop_i(stop_i),
    .address_valid_i(address_valid_i), .address_i(address_i),
    .data_valid_i(data_valid_i), .data_i(data_i),
    .reg_wr_en_o(reg_wr_en_o), .reg_wr_addr_o(reg_wr_addr_o),
    .reg_wr_data_o(reg_wr_data_o), .commit_o(commit_o),
    .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: what the outputs show after the next clock edge.
  bit         m_we, m_cm, m_busy, m_err, m_sup, m_dirty;
  logic [3:0] m_ptr, m_wa;
  logic [7:0] m_wd;
  // Expectations for the current cycle.
  bit         e_we, e_cm, e_busy, e_err;
  logic [3:0] e_wa;
  logic [7:0] e_wd;
  bit         cmp_en = 1'b0;

  logic [11:0] obs_q[$];
  int          n_commit = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] nxt_ptr(input logic [3:0] p);
`ifdef I2C_REG_CTRL_AUTOINC_EN
    return 4'((int'(p) + 1) % 16);
`else
    return p;
`endif
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("wr_en", reg_wr_en_o, e_we);
      if (e_we) begin
        chk("wr_addr", reg_wr_addr_o, e_wa);
        chk("wr_data", reg_wr_data_o, e_wd);
      end
      chk("commit", commit_o, e_cm);
      chk("busy", busy_o, e_busy);
      chk("err", err_o, e_err);
      if (reg_wr_en_o === 1'b1) obs_q.push_back({reg_wr_addr_o, reg_wr_data_o});
      if (commit_o === 1'b1) n_commit++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    e_we = m_we; e_wa = m_wa; e_wd = m_wd; e_cm = m_cm;
    e_busy = m_busy; e_err = m_err;
    m_we = 1'b0; m_cm = 1'b0;
    cmp_en = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1; start_i = 1'b0; stop_i = 1'b0;
    address_valid_i = 1'b0; data_valid_i = 1'b0;
    m_we = 0; m_cm = 0; m_busy = 0; m_err = 0; m_sup = 0; m_dirty = 0;
    m_ptr = 4'd0; m_wa = 4'd0; m_wd = 8'd0;
    tick();
    reset = 1'b0;
  endtask

  task automatic do_start(input bit with_stop);
    start_i = 1'b1; stop_i = with_stop; address_valid_i = 1'b0;
    m_busy = 1; m_err = 0; m_sup = 0;
    tick();
    start_i = 1'b0; stop_i = 1'b0;
  endtask

  task automatic do_addr(input logic [7:0] a);
    address_i = a; address_valid_i = 1'b1;
    m_ptr = a[3:0];
    if (a >= 8'd16) begin m_err = 1; m_sup = 1; end
    tick();
  endtask

  // stop_i is already high in the current cycle.
  task automatic stop_effect(input bit sic, output bit in_aw);
    in_aw = 1'b0;
    if (m_dirty) begin
      m_cm = 1; m_dirty = 0;
      tick();
      stop_i = 1'b0;
      if (sic) begin
        start_i = 1'b1; address_valid_i = 1'b0; m_err = 0; m_sup = 0; in_aw = 1'b1;
      end else begin
        m_busy = 0;
      end
      tick();
      start_i = 1'b0;
    end else begin
      m_busy = 0;
      tick();
      stop_i = 1'b0;
    end
  endtask

  task automatic do_stop(input bit sic, output bit in_aw);
    stop_i = 1'b1;
    stop_effect(sic, in_aw);
  endtask

  // mode: 0 plain, 1 STOP during write, 2 START during write, 3 START+STOP during write
  task automatic do_data(input logic [7:0] d, input int mode, input bit sic,
                         output bit ended, output bit in_aw);
    data_i = d; data_valid_i = 1'b1;
    if (!m_sup) begin m_we = 1; m_wa = m_ptr; m_wd = d; m_dirty = 1; end
    tick();
    data_valid_i = 1'b0;
    m_ptr = nxt_ptr(m_ptr);
    ended = 1'b0; in_aw = 1'b0;
    if (mode >= 2) begin
      start_i = 1'b1; stop_i = (mode == 3); address_valid_i = 1'b0;
      m_err = 0; m_sup = 0;
      tick();
      start_i = 1'b0; stop_i = 1'b0;
      ended = 1'b1; in_aw = 1'b1;
    end else if (mode == 1) begin
      stop_i = 1'b1;
      stop_effect(sic, in_aw);
      ended = 1'b1;
    end else begin
      tick();
    end
  endtask

  task automatic chk_wr(input string name, input int idx, input logic [11:0] exp);
    logic [11:0] got;
    got = (obs_q.size() > idx) ? obs_q[idx] : 12'hfff;
    chk(name, got, exp);
  endtask

  task automatic clear_log();
    obs_q.delete();
    n_commit = 0;
  endtask

  bit ended, in_aw, sic;
  int n, mode, r;
  logic [7:0] a;

  initial begin
    // Reset state
    do_reset();
    chk("rst_wr_en", reg_wr_en_o, 1'b0);
    chk("rst_wr_addr", reg_wr_addr_o, 4'h0);
    chk("rst_wr_data", reg_wr_data_o, 8'h00);
    chk("rst_commit", commit_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_err", err_o, 1'b0);

    // Single write then STOP
    clear_log();
    do_start(0); do_addr(8'h03); idle(1);
    do_data(8'hAA, 0, 0, ended, in_aw);
    do_stop(0, in_aw); idle(1);
    chk("t1_nwr", obs_q.size(), 1);
    chk_wr("t1_wr0", 0, 12'h3AA);
    chk("t1_ncommit", n_commit, 1);
    chk("t1_busy", busy_o, 1'b0);

    // Three bytes starting at 14
    clear_log();
    do_start(0); do_addr(8'h0E);
    do_data(8'h11, 0, 0, ended, in_aw);
    do_data(8'h22, 0, 0, ended, in_aw);
    do_data(8'h33, 0, 0, ended, in_aw);
    do_stop(0, in_aw); idle(1);
    chk("t2_nwr", obs_q.size(), 3);
`ifdef I2C_REG_CTRL_AUTOINC_EN
    chk_wr("t2_wr0", 0, 12'hE11);
    chk_wr("t2_wr1", 1, 12'hF22);
    chk_wr("t2_wr2", 2, 12'h033);
`else
    chk_wr("t2_wr0", 0, 12'hE11);
    chk_wr("t2_wr1", 1, 12'hE22);
    chk_wr("t2_wr2", 2, 12'hE33);
`endif
    chk("t2_ncommit", n_commit, 1);

    // Out-of-range address
    clear_log();
    do_start(0); do_addr(8'h20);
    chk("t3_err_set", err_o, 1'b1);
    do_data(8'h55, 0, 0, ended, in_aw);
    do_stop(0, in_aw); idle(1);
    chk("t3_nwr", obs_q.size(), 0);
    chk("t3_ncommit", n_commit, 0);
    chk("t3_err_sticky", err_o, 1'b1);
    do_start(0);
    chk("t3_err_clr", err_o, 1'b0);
    do_stop(0, in_aw);

    // Write, repeated START, read-style address, STOP
    clear_log();
    do_start(0); do_addr(8'h02);
    do_data(8'h5A, 0, 0, ended, in_aw);
    do_start(0); do_addr(8'h05); idle(2);
    chk("t4_no_early_commit", n_commit, 0);
    do_stop(0, in_aw); idle(1);
    chk("t4_nwr", obs_q.size(), 1);
    chk_wr("t4_wr0", 0, 12'h25A);
    chk("t4_ncommit", n_commit, 1);

    // STOP in the WRITE cycle
    clear_log();
    do_start(0); do_addr(8'h07);
    do_data(8'h77, 1, 0, ended, in_aw); idle(1);
    chk("t5_nwr", obs_q.size(), 1);
    chk_wr("t5_wr0", 0, 12'h777);
    chk("t5_ncommit", n_commit, 1);

    // Reset mid-transaction discards the pending commit
    clear_log();
    do_start(0); do_addr(8'h01);
    do_data(8'h10, 0, 0, ended, in_aw);
    do_reset();
    chk("t6_busy", busy_o, 1'b0);
    chk("t6_wr_en", reg_wr_en_o, 1'b0);
    do_stop(0, in_aw); idle(2);
    chk("t6_ncommit", n_commit, 0);

    // Randomized traffic
    in_aw = 1'b0;
    for (int t = 0; t < 250; t++) begin
      if (!in_aw) do_start($urandom_range(0, 4) == 0);
      in_aw = 1'b0;
      a = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(16, 255)) : 8'($urandom_range(0, 15));
      do_addr(a);
      idle($urandom_range(0, 2));
      n = $urandom_range(0, 3);
      ended = 1'b0;
      for (int k = 0; k < n && !ended; k++) begin
        mode = (k == n - 1 && $urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
        sic = ($urandom_range(0, 3) == 0);
        do_data(8'($urandom_range(0, 255)), mode, sic, ended, in_aw);
        if (!ended) idle($urandom_range(0, 2));
      end
      if (!ended) begin
        r = $urandom_range(0, 9);
        if (r < 6) begin
          do_stop($urandom_range(0, 3) == 0, in_aw);
        end else if (r == 9) begin
          do_reset();
          in_aw = 1'b0;
        end
      end
      if (!in_aw) idle($urandom_range(0, 2));
    end
    do_stop(0, in_aw);
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
